hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter VECTOR_BASE, default 14'h0040: base program address of the interrupt vector table.
REQ-002 Parameter EXC_VECTOR, default 14'h0008: illegal-opcode handler address.
REQ-003 Parameter HW_CALL_WORD, default 32'hBC00_0000: instruction word injected into IF/ID on an interrupt or exception entry.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 nreset  in  1  asynchronous, active-low reset.
REQ-006 irq_req  in  8  level interrupt requests; bit 0 is highest priority.
REQ-007 irq_ack  out  8  one-hot, single-cycle pulse in the INJECT cycle of the serviced irq.
REQ-008 dec_stall_fetch, dec_stall_decode  in  1 each  stall requests from the decode stage.
REQ-009 halt, illegal_opcode_exception, return_in_pipeline  in  1 each  decode-stage status flags.
REQ-010 reti_retired  in  1  single-cycle pulse when a return-from-interrupt leaves writeback.
REQ-011 stall_fetch, stall_decode  out  1 each  stall controls to the datapath.
REQ-012 hazard_prog_cntr_sel  out  3  PC source: 000 normal, 001 vector, 100 hold.
REQ-013 inst_word_sel  out  1  1 selects hazard_inst_word over the program-memory word.
REQ-014 hazard_inst_word  out  32  constant HW_CALL_WORD.
REQ-015 prog_cntr_int_addr  out  14  registered vector address.
REQ-016 in_service, halted  out  1 each  status flags.
REQ-017 mask_wr_en  in  1; mask_wr_data  in  8  interrupt mask write port (see Configuration).

Function
REQ-018 FSM states: IDLE, DRAIN, INJECT, SERVICE, HALTED.
REQ-019 IDLE: stall_fetch/stall_decode = dec_stall_*; hazard_prog_cntr_sel = 000; inst_word_sel = 0.
REQ-020 Pending set = irq_req & mask; winner = lowest set index.
REQ-021 Entry priority when IDLE: illegal_opcode_exception > halt > pending irq.
REQ-022 Exception or irq entry from IDLE: go to DRAIN; latch target (EXC_VECTOR, or VECTOR_BASE + 8*index; modulo 2^14) into prog_cntr_int_addr.
REQ-023 DRAIN: assert both stalls; sel = 100; remain while return_in_pipeline = 1; go to INJECT the cycle after it reads 0 (minimum one cycle in DRAIN).
REQ-024 INJECT, exactly one cycle: inst_word_sel = 1; sel = 001; stalls deasserted; irq_ack pulses (irq entry only); then go to SERVICE.
REQ-025 SERVICE: behaves as IDLE for stalls and selects, but no new entry; illegal_opcode_exception in SERVICE re-enters DRAIN with EXC_VECTOR.
REQ-026 SERVICE: reti_retired returns the FSM to IDLE; a still-pending irq is taken on the following cycle.
REQ-027 halt in IDLE: go to HALTED; both stalls asserted; sel = 100; halted = 1.
REQ-028 HALTED exits to DRAIN only on a pending irq; illegal_opcode_exception is ignored while HALTED.
REQ-029 Simultaneous reti_retired and illegal_opcode_exception in SERVICE: the exception wins.
REQ-030 in_service = 1 in states DRAIN, INJECT, SERVICE.
REQ-031 Irq requests deasserted during DRAIN do not cancel the entry; the latched vector is used.

Reset
REQ-032 nreset low forces, asynchronously: state IDLE; prog_cntr_int_addr 0; irq_ack 0; in_service 0; halted 0; inst_word_sel 0; sel 000; mask 8'hFF.
REQ-033 Stall outputs follow dec_stall_* combinationally during reset.
REQ-034 Reset asserted mid-DRAIN or mid-INJECT abandons the entry; no irq_ack is issued.

Configuration
REQ-035 With HAZARD_IRQ_MASK_EN defined: an 8-bit mask register loads mask_wr_data when mask_wr_en = 1 and gates irq_req.
REQ-036 Without HAZARD_IRQ_MASK_EN: mask is constant 8'hFF, and mask_wr_en/mask_wr_data are ignored.

Verification
REQ-037 irq_req = 8'h0A in IDLE, return_in_pipeline = 0 -> one DRAIN cycle, INJECT with prog_cntr_int_addr = 14'h0048, irq_ack = 8'h02, inst_word_sel = 1 for exactly 1 cycle.
REQ-038 irq_req[0] with return_in_pipeline held 3 cycles -> DRAIN lasts 4 cycles with stalls = 1 and sel = 100, then INJECT to 14'h0040.
REQ-039 halt pulse, then irq_req[7] 5 cycles later -> halted = 1 until then; entry to 14'h0078.
REQ-040 illegal_opcode_exception together with irq_req[0] -> vector 14'h0008, no irq_ack; irq taken after reti_retired.
REQ-041 HAZARD_IRQ_MASK_EN: write mask 8'hFE, raise irq_req[0] -> no entry; write 8'hFF -> entry to 14'h0040.
REQ-042 nreset pulsed during DRAIN -> all outputs return to reset values immediately; no irq_ack observed.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Bus bundle between the hazard unit and the pipeline datapath / decode stage.
// The hazard unit uses the slave modport; the datapath side uses master.
interface hazard_unit_if;
  logic [7:0]  irq_req;
  logic [7:0]  irq_ack;
  logic        dec_stall_fetch;
  logic        dec_stall_decode;
  logic        halt;
  logic        illegal_opcode_exception;
  logic        return_in_pipeline;
  logic        reti_retired;
  logic        stall_fetch;
  logic        stall_decode;
  logic [2:0]  hazard_prog_cntr_sel;
  logic        inst_word_sel;
  logic [31:0] hazard_inst_word;
  logic [13:0] prog_cntr_int_addr;
  logic        in_service;
  logic        halted;
  logic        mask_wr_en;
  logic [7:0]  mask_wr_data;

  modport slave (
    input  irq_req, dec_stall_fetch, dec_stall_decode, halt,
           illegal_opcode_exception, return_in_pipeline, reti_retired,
           mask_wr_en, mask_wr_data,
    output irq_ack, stall_fetch, stall_decode, hazard_prog_cntr_sel,
           inst_word_sel, hazard_inst_word, prog_cntr_int_addr,
           in_service, halted
  );

  modport master (
    output irq_req, dec_stall_fetch, dec_stall_decode, halt,
           illegal_opcode_exception, return_in_pipeline, reti_retired,
           mask_wr_en, mask_wr_data,
    input  irq_ack, stall_fetch, stall_decode, hazard_prog_cntr_sel,
           inst_word_sel, hazard_inst_word, prog_cntr_int_addr,
           in_service, halted
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: interrupt/exception entry (drain, inject call word, service) and halt.
// Optional HAZARD_IRQ_MASK_EN adds a writable 8-bit interrupt mask register.
module hazard_unit #(
  parameter logic [13:0] VECTOR_BASE  = 14'h0040,
  parameter logic [13:0] EXC_VECTOR   = 14'h0008,
  parameter logic [31:0] HW_CALL_WORD = 32'hBC00_0000
) (
  input logic          clock,
  input logic          nreset,
  hazard_unit_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_INJECT  = 3'd2,
    ST_SERVICE = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic        irq_entry_q, irq_entry_d;
  logic [2:0]  irq_idx_q, irq_idx_d;
  logic [7:0]  irq_ack_q, irq_ack_d;
  logic [2:0]  sel_q, sel_d;
  logic        inject_q, inject_d;
  logic        force_stall_q, force_stall_d;
  logic        in_service_q, in_service_d;
  logic        halted_q, halted_d;
  logic [7:0]  mask_s;
  logic [7:0]  pending_s;
  logic        pend_any_s;
  logic [2:0]  win_idx_s;
  logic [13:0] irq_vec_s;

  function automatic logic [2:0] prio_idx(input logic [7:0] req);
    prio_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) prio_idx = 3'(i);
    end
  endfunction

`ifdef HAZARD_IRQ_MASK_EN
  logic [7:0] mask_q;

  // Interrupt mask register, all sources enabled out of reset.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      mask_q <= 8'hFF;
    end else if (bus.mask_wr_en) begin
      mask_q <= bus.mask_wr_data;
    end
  end
  assign mask_s = mask_q;
`else
  logic unused_mask_s;
  assign mask_s        = 8'hFF;
  assign unused_mask_s = ^{bus.mask_wr_en, bus.mask_wr_data};
`endif

  assign pending_s  = bus.irq_req & mask_s;
  assign pend_any_s = |pending_s;
  assign win_idx_s  = prio_idx(pending_s);
  assign irq_vec_s  = VECTOR_BASE + {8'd0, win_idx_s, 3'b000};

  // Next-state logic and entry-target latching.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    irq_entry_d = irq_entry_q;
    irq_idx_d   = irq_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.illegal_opcode_exception) begin
          state_d     = ST_DRAIN;
          addr_d      = EXC_VECTOR;
          irq_entry_d = 1'b0;
        end else if (bus.halt) begin
          state_d = ST_HALTED;
        end else if (pend_any_s) begin
          state_d     = ST_DRAIN;
          addr_d      = irq_vec_s;
          irq_entry_d = 1'b1;
          irq_idx_d   = win_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.return_in_pipeline) state_d = ST_DRAIN;
        else                        state_d = ST_INJECT;
      end
      ST_INJECT: state_d = ST_SERVICE;
      ST_SERVICE: begin
        // An exception beats a simultaneous return-from-interrupt.
        if (bus.illegal_opcode_exception) begin
          state_d     = ST_DRAIN;
          addr_d      = EXC_VECTOR;
          irq_entry_d = 1'b0;
        end else if (bus.reti_retired) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      ST_HALTED: begin
        if (pend_any_s) begin
          state_d     = ST_DRAIN;
          addr_d      = irq_vec_s;
          irq_entry_d = 1'b1;
          irq_idx_d   = win_idx_s;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state so every control is a flop output.
  always_comb begin
    irq_ack_d     = 8'h00;
    sel_d         = 3'b000;
    inject_d      = 1'b0;
    force_stall_d = 1'b0;
    in_service_d  = 1'b0;
    halted_d      = 1'b0;
    case (state_d)
      ST_DRAIN: begin
        sel_d         = 3'b100;
        force_stall_d = 1'b1;
        in_service_d  = 1'b1;
      end
      ST_INJECT: begin
        sel_d        = 3'b001;
        inject_d     = 1'b1;
        in_service_d = 1'b1;
        if (irq_entry_d) irq_ack_d = 8'h01 << irq_idx_d;
        else             irq_ack_d = 8'h00;
      end
      ST_SERVICE: in_service_d = 1'b1;
      ST_HALTED: begin
        sel_d         = 3'b100;
        force_stall_d = 1'b1;
        halted_d      = 1'b1;
      end
      ST_IDLE: sel_d = 3'b000;
      default: sel_d = 3'b000;
    endcase
  end

  // State and registered control outputs.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ST_IDLE;
      addr_q        <= 14'h0000;
      irq_entry_q   <= 1'b0;
      irq_idx_q     <= 3'd0;
      irq_ack_q     <= 8'h00;
      sel_q         <= 3'b000;
      inject_q      <= 1'b0;
      force_stall_q <= 1'b0;
      in_service_q  <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      irq_entry_q   <= irq_entry_d;
      irq_idx_q     <= irq_idx_d;
      irq_ack_q     <= irq_ack_d;
      sel_q         <= sel_d;
      inject_q      <= inject_d;
      force_stall_q <= force_stall_d;
      in_service_q  <= in_service_d;
      halted_q      <= halted_d;
    end
  end

  // Stalls pass the decode requests through unless draining/halted or injecting.
  assign bus.stall_fetch  = force_stall_q | (~inject_q & bus.dec_stall_fetch);
  assign bus.stall_decode = force_stall_q | (~inject_q & bus.dec_stall_decode);

  assign bus.irq_ack              = irq_ack_q;
  assign bus.hazard_prog_cntr_sel = sel_q;
  assign bus.inst_word_sel        = inject_q;
  assign bus.hazard_inst_word     = HW_CALL_WORD;
  assign bus.prog_cntr_int_addr   = addr_q;
  assign bus.in_service           = in_service_q;
  assign bus.halted               = halted_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; each task drives one scenario and checks inline.
module tb_hazard_unit;
  logic clock = 1'b0;
  logic nreset;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  hazard_unit_if bus ();

  hazard_unit dut (.clock(clock), .nreset(nreset), .bus(bus));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.irq_req = 8'h00; bus.dec_stall_fetch = 1'b0; bus.dec_stall_decode = 1'b0;
    bus.halt = 1'b0; bus.illegal_opcode_exception = 1'b0; bus.return_in_pipeline = 1'b0;
    bus.reti_retired = 1'b0; bus.mask_wr_en = 1'b0; bus.mask_wr_data = 8'h00;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    clear_inputs();
    bus.dec_stall_fetch = 1'b1;
    #3;
    total_cnt++; if (bus.stall_fetch !== 1'b1 || bus.stall_decode !== 1'b0) $display("FAIL rst_stall got %b%b exp 10", bus.stall_fetch, bus.stall_decode); else pass_cnt++;
    total_cnt++; if (bus.hazard_prog_cntr_sel !== 3'b000 || bus.inst_word_sel !== 1'b0) $display("FAIL rst_sel got %b/%b exp 000/0", bus.hazard_prog_cntr_sel, bus.inst_word_sel); else pass_cnt++;
    total_cnt++; if (bus.prog_cntr_int_addr !== 14'h0000 || bus.irq_ack !== 8'h00) $display("FAIL rst_addr_ack got %h/%h exp 0000/00", bus.prog_cntr_int_addr, bus.irq_ack); else pass_cnt++;
    total_cnt++; if (bus.in_service !== 1'b0 || bus.halted !== 1'b0) $display("FAIL rst_flags got %b%b exp 00", bus.in_service, bus.halted); else pass_cnt++;
    total_cnt++; if (bus.hazard_inst_word !== 32'hBC00_0000) $display("FAIL inst_word got %h exp bc000000", bus.hazard_inst_word); else pass_cnt++;
    bus.dec_stall_fetch = 1'b0;
    @(negedge clock);
    nreset = 1'b1;
    tick();
  endtask

  // Finishes an entry from SERVICE with a reti pulse and lands in IDLE.
  task automatic leave_service();
    bus.reti_retired = 1'b1;
    tick();
    bus.reti_retired = 1'b0;
  endtask

  task automatic test_irq_basic();
    bus.irq_req = 8'h0A;
    tick();
    total_cnt++; if (bus.hazard_prog_cntr_sel !== 3'b100 || bus.stall_fetch !== 1'b1 || bus.stall_decode !== 1'b1) $display("FAIL basic_drain got sel %b st %b%b exp 100 11", bus.hazard_prog_cntr_sel, bus.stall_fetch, bus.stall_decode); else pass_cnt++;
    total_cnt++; if (bus.prog_cntr_int_addr !== 14'h0048 || bus.in_service !== 1'b1 || bus.irq_ack !== 8'h00) $display("FAIL basic_addr got %h/%b/%h exp 0048/1/00", bus.prog_cntr_int_addr, bus.in_service, bus.irq_ack); else pass_cnt++;
    bus.irq_req = 8'h00;
    tick();
    total_cnt++; if (bus.inst_word_sel !== 1'b1 || bus.hazard_prog_cntr_sel !== 3'b001 || bus.irq_ack !== 8'h02) $display("FAIL basic_inject got iws %b sel %b ack %h exp 1 001 02", bus.inst_word_sel, bus.hazard_prog_cntr_sel, bus.irq_ack); else pass_cnt++;
    total_cnt++; if (bus.stall_fetch !== 1'b0 || bus.stall_decode !== 1'b0 || bus.prog_cntr_int_addr !== 14'h0048) $display("FAIL basic_inj_stall got %b%b addr %h exp 00 0048", bus.stall_fetch, bus.stall_decode, bus.prog_cntr_int_addr); else pass_cnt++;
    tick();
    total_cnt++; if (bus.inst_word_sel !== 1'b0 || bus.irq_ack !== 8'h00 || bus.in_service !== 1'b1 || bus.hazard_prog_cntr_sel !== 3'b000) $display("FAIL basic_service got iws %b ack %h ins %b sel %b exp 0 00 1 000", bus.inst_word_sel, bus.irq_ack, bus.in_service, bus.hazard_prog_cntr_sel); else pass_cnt++;
    bus.dec_stall_fetch = 1'b1;
    #1;
    total_cnt++; if (bus.stall_fetch !== 1'b1 || bus.stall_decode !== 1'b0) $display("FAIL service_passthru got %b%b exp 10", bus.stall_fetch, bus.stall_decode); else pass_cnt++;
    bus.dec_stall_fetch = 1'b0;
    leave_service();
    total_cnt++; if (bus.in_service !== 1'b0) $display("FAIL basic_idle got in_service %b exp 0", bus.in_service); else pass_cnt++;
  endtask

  task automatic test_drain_hold();
    logic drain_ok;
    drain_ok = 1'b1;
    bus.irq_req = 8'h01;
    bus.return_in_pipeline = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.hazard_prog_cntr_sel !== 3'b100 || bus.stall_fetch !== 1'b1 || bus.stall_decode !== 1'b1 || bus.inst_word_sel !== 1'b0) drain_ok = 1'b0;
      if (i == 4) bus.return_in_pipeline = 1'b0;
    end
    total_cnt++; if (drain_ok !== 1'b1) $display("FAIL drain_hold got %b exp 1", drain_ok); else pass_cnt++;
    tick();
    total_cnt++; if (bus.inst_word_sel !== 1'b1 || bus.prog_cntr_int_addr !== 14'h0040 || bus.irq_ack !== 8'h01) $display("FAIL drain_inject got iws %b addr %h ack %h exp 1 0040 01", bus.inst_word_sel, bus.prog_cntr_int_addr, bus.irq_ack); else pass_cnt++;
    tick();
    leave_service();
    total_cnt++; if (bus.in_service !== 1'b0) $display("FAIL reti_idle got %b exp 0", bus.in_service); else pass_cnt++;
    tick();
    total_cnt++; if (bus.in_service !== 1'b1 || bus.hazard_prog_cntr_sel !== 3'b100) $display("FAIL still_pending got ins %b sel %b exp 1 100", bus.in_service, bus.hazard_prog_cntr_sel); else pass_cnt++;
    bus.irq_req = 8'h00;
    tick();
    tick();
    leave_service();
  endtask

  task automatic test_halt();
    logic halt_ok;
    halt_ok = 1'b1;
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    total_cnt++; if (bus.halted !== 1'b1 || bus.stall_fetch !== 1'b1 || bus.stall_decode !== 1'b1 || bus.hazard_prog_cntr_sel !== 3'b100) $display("FAIL halt_enter got h %b st %b%b sel %b exp 1 11 100", bus.halted, bus.stall_fetch, bus.stall_decode, bus.hazard_prog_cntr_sel); else pass_cnt++;
    bus.illegal_opcode_exception = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.illegal_opcode_exception = 1'b0;
      if (bus.halted !== 1'b1 || bus.in_service !== 1'b0) halt_ok = 1'b0;
    end
    total_cnt++; if (halt_ok !== 1'b1) $display("FAIL halt_stay got %b exp 1", halt_ok); else pass_cnt++;
    bus.irq_req = 8'h80;
    tick();
    bus.irq_req = 8'h00;
    total_cnt++; if (bus.halted !== 1'b0 || bus.in_service !== 1'b1 || bus.prog_cntr_int_addr !== 14'h0078) $display("FAIL halt_exit got h %b ins %b addr %h exp 0 1 0078", bus.halted, bus.in_service, bus.prog_cntr_int_addr); else pass_cnt++;
    tick();
    total_cnt++; if (bus.irq_ack !== 8'h80) $display("FAIL halt_ack got %h exp 80", bus.irq_ack); else pass_cnt++;
    tick();
    leave_service();
  endtask

  task automatic test_exception();
    bus.illegal_opcode_exception = 1'b1;
    bus.irq_req = 8'h01;
    tick();
    bus.illegal_opcode_exception = 1'b0;
    total_cnt++; if (bus.prog_cntr_int_addr !== 14'h0008 || bus.in_service !== 1'b1) $display("FAIL exc_vec got %h ins %b exp 0008 1", bus.prog_cntr_int_addr, bus.in_service); else pass_cnt++;
    tick();
    total_cnt++; if (bus.inst_word_sel !== 1'b1 || bus.irq_ack !== 8'h00) $display("FAIL exc_noack got iws %b ack %h exp 1 00", bus.inst_word_sel, bus.irq_ack); else pass_cnt++;
    tick();
    bus.illegal_opcode_exception = 1'b1;
    bus.reti_retired = 1'b1;
    tick();
    bus.illegal_opcode_exception = 1'b0;
    bus.reti_retired = 1'b0;
    total_cnt++; if (bus.hazard_prog_cntr_sel !== 3'b100 || bus.in_service !== 1'b1 || bus.prog_cntr_int_addr !== 14'h0008) $display("FAIL exc_beats_reti got sel %b ins %b addr %h exp 100 1 0008", bus.hazard_prog_cntr_sel, bus.in_service, bus.prog_cntr_int_addr); else pass_cnt++;
    tick();
    total_cnt++; if (bus.irq_ack !== 8'h00 || bus.inst_word_sel !== 1'b1) $display("FAIL exc2_noack got ack %h iws %b exp 00 1", bus.irq_ack, bus.inst_word_sel); else pass_cnt++;
    tick();
    leave_service();
    tick();
    total_cnt++; if (bus.prog_cntr_int_addr !== 14'h0040 || bus.in_service !== 1'b1) $display("FAIL exc_then_irq got %h ins %b exp 0040 1", bus.prog_cntr_int_addr, bus.in_service); else pass_cnt++;
    bus.irq_req = 8'h00;
    tick();
    total_cnt++; if (bus.irq_ack !== 8'h01) $display("FAIL exc_then_ack got %h exp 01", bus.irq_ack); else pass_cnt++;
    tick();
    leave_service();
  endtask

  task automatic test_mask();
    bus.mask_wr_en = 1'b1;
    bus.mask_wr_data = 8'hFE;
    tick();
    bus.mask_wr_en = 1'b0;
    bus.irq_req = 8'h01;
`ifdef HAZARD_IRQ_MASK_EN
    tick();
    tick();
    total_cnt++; if (bus.in_service !== 1'b0) $display("FAIL mask_block got %b exp 0", bus.in_service); else pass_cnt++;
    bus.mask_wr_en = 1'b1;
    bus.mask_wr_data = 8'hFF;
    tick();
    bus.mask_wr_en = 1'b0;
    total_cnt++; if (bus.in_service !== 1'b0) $display("FAIL mask_wr_edge got %b exp 0", bus.in_service); else pass_cnt++;
    tick();
`else
    tick();
`endif
    total_cnt++; if (bus.in_service !== 1'b1 || bus.prog_cntr_int_addr !== 14'h0040) $display("FAIL mask_entry got ins %b addr %h exp 1 0040", bus.in_service, bus.prog_cntr_int_addr); else pass_cnt++;
    bus.irq_req = 8'h00;
    tick();
    tick();
    leave_service();
  endtask

  task automatic test_reset_in_drain();
    logic ack_seen;
    ack_seen = 1'b0;
    bus.irq_req = 8'h04;
    tick();
    total_cnt++; if (bus.prog_cntr_int_addr !== 14'h0050 || bus.in_service !== 1'b1) $display("FAIL rd_drain got %h ins %b exp 0050 1", bus.prog_cntr_int_addr, bus.in_service); else pass_cnt++;
    #1;
    nreset = 1'b0;
    #1;
    total_cnt++; if (bus.in_service !== 1'b0 || bus.prog_cntr_int_addr !== 14'h0000 || bus.hazard_prog_cntr_sel !== 3'b000 || bus.stall_fetch !== 1'b0 || bus.stall_decode !== 1'b0) $display("FAIL rd_async got ins %b addr %h sel %b st %b%b exp 0 0000 000 00", bus.in_service, bus.prog_cntr_int_addr, bus.hazard_prog_cntr_sel, bus.stall_fetch, bus.stall_decode); else pass_cnt++;
    bus.irq_req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.irq_ack !== 8'h00) ack_seen = 1'b1;
      if (i == 0) nreset = 1'b1;
    end
    total_cnt++; if (ack_seen !== 1'b0 || bus.in_service !== 1'b0) $display("FAIL rd_noack got ack %b ins %b exp 0 0", ack_seen, bus.in_service); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_irq_basic();
    test_drain_hold();
    test_halt();
    test_exception();
    test_mask();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
